// File: rtl/fifo_pkg.sv
// Shared types and constants for the read-side FIFO drain controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_pkg;

    // Drain controller phases: idle, issuing reads, waiting for the tail to leave
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    // Words the output buffer can hold; reads in flight count against this too
    localparam int DRAIN_SKID_DEPTH = 2;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry registered buffer between the FIFO read port and the downstream stream.
// Latency: a word pushed in cycle N is presented on out_valid in cycle N+1.
// Backpressure: holds up to two words while out_ready=0; the writer must respect occupancy.
module drain_skid_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_data0;   // head word, drives out_data
    logic [WIDTH-1:0] r_data1;   // second word, only meaningful when r_occ==2
    logic [1:0]       r_occ;
    logic             w_pop;

    assign w_pop     = (r_occ != 2'd0) && out_ready;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_data0;
    assign occupancy = r_occ;

    // Push/pop bookkeeping; head stays put while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_occ   <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (in_valid) begin
                        r_data0 <= in_data;
                        r_occ   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && w_pop) begin
                        r_data0 <= in_data;
                    end else if (w_pop) begin
                        r_occ   <= 2'd0;
                    end else if (in_valid) begin
                        r_data1 <= in_data;
                        r_occ   <= 2'd2;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_data0 <= r_data1;
                        if (in_valid) begin
                            r_data1 <= in_data;
                        end else begin
                            r_occ   <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_drain.sv
// Read-domain burst drain of an async FIFO into a valid/ready stream (optional FIFO_SEQ_CHECK_EN sequence checker).
// Latency: rd_en in cycle N, rd_data captured at end of N+1, out_valid from N+2; back-to-back reads at full rate.
// Backpressure: reads pause once buffered + in-flight words reach 2; no word is dropped or repeated.
module fifo_read_drain
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int BURST_LEN = 8,
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             empty,
    output logic             rd_en,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             start,
    input  logic             stop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rd_count
`ifdef FIFO_SEQ_CHECK_EN
    ,
    output logic             seq_err
`endif
);

    drain_state_t     r_state;
    drain_state_t     w_state_nxt;
    logic             r_in_flight;   // rd_data of the previous cycle's rd_en is valid now
    logic [CNT_W-1:0] r_rd_count;
    logic             r_done;
    logic             w_finish;

    logic             w_skid_vld;
    logic [WIDTH-1:0] w_skid_dat;
    logic [1:0]       w_occ;
    logic             w_pop;
    logic [1:0]       w_occ_eff;
    logic [1:0]       w_load;
    logic             w_room;
    logic             w_below;
    logic             w_rd_en;

    drain_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (rclk),
        .rst       (reset),
        .in_valid  (r_in_flight),
        .in_data   (rd_data),
        .out_valid (w_skid_vld),
        .out_data  (w_skid_dat),
        .out_ready (out_ready),
        .occupancy (w_occ)
    );

    // A word leaving this cycle frees its slot now, which keeps reads back-to-back
    // when the consumer is always ready.
    assign w_pop     = w_skid_vld && out_ready;
    assign w_occ_eff = w_occ - {1'b0, w_pop};
    assign w_load    = w_occ_eff + {1'b0, r_in_flight};
    assign w_room    = (w_load < 2'(DRAIN_SKID_DEPTH));
    assign w_below   = (r_rd_count < CNT_W'(BURST_LEN));
    // A stop pulse also blocks the read in its own cycle so nothing follows it.
    assign w_rd_en   = (r_state == DRAIN) && !empty && w_below && w_room && !stop;

    assign rd_en     = w_rd_en;
    assign out_valid = w_skid_vld;
    assign out_data  = w_skid_dat;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign rd_count  = r_rd_count;

    // Next-state: start/stop handling and completion once the tail has left
    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = stop ? FLUSH : DRAIN;
                end
            end
            DRAIN: begin
                if (stop || (r_rd_count == CNT_W'(BURST_LEN))) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (!r_in_flight && (w_occ_eff == 2'd0)) begin
                    w_state_nxt = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register, in-flight flag, burst counter and done pulse
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_flight <= 1'b0;
            r_rd_count  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_flight <= w_rd_en;
            r_done      <= w_finish;
            if ((r_state == IDLE) && start) begin
                r_rd_count <= '0;
            end else if (w_rd_en && w_below) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
        end
    end

`ifdef FIFO_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_seq_exp;
    logic             r_seq_err;

    assign seq_err = r_seq_err;

    // Captured words must count up from zero within each burst; error is sticky
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_seq_exp <= '0;
            r_seq_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_seq_exp <= '0;
            r_seq_err <= 1'b0;
        end else if (r_in_flight) begin
            if (rd_data != r_seq_exp) begin
                r_seq_err <= 1'b1;
            end
            r_seq_exp <= r_seq_exp + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: FIFO model, random backpressure/empty stimulus, scoreboard monitor.
// Latency: n/a.
// Backpressure: out_ready driven per test mode (always, random, held low).
module tb_fifo_read_drain;

    localparam int WIDTH = 4;
    localparam int BL    = 8;
    localparam int CW    = $clog2(BL + 1);

    logic             rclk = 1'b0;
    logic             reset;
    logic             empty;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             start;
    logic             stop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CW-1:0]    rd_count;
`ifdef FIFO_SEQ_CHECK_EN
    logic             seq_err;
`endif

    fifo_read_drain #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
        .rclk      (rclk),
        .reset     (reset),
        .empty     (empty),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .start     (start),
        .stop      (stop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count)
`ifdef FIFO_SEQ_CHECK_EN
        ,
        .seq_err   (seq_err)
`endif
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] fifo_q[$];   // FIFO contents as seen by the read port
    logic [WIDTH-1:0] exp_q[$];    // words the stream must deliver, in order

    bit force_empty = 0;
    bit toggle_en   = 0;
    int ready_mode  = 0;           // 0 always ready, 1 random, 2 held low for hold_cnt cycles
    int hold_cnt    = 0;
    int rd_en_total = 0;
    int done_cnt    = 0;
    int exp_count   = 0;
    bit chk_latency = 0;
    int last_xfer   = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic upd_empty();
        empty = (fifo_q.size() == 0) || force_empty;
    endtask

    always @(posedge rclk) cyc++;

    // Environment: FIFO read port model, empty toggling and out_ready driving
    initial begin
        bit pop_now;
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge rclk);
            pop_now = rd_en && !reset;
            if (pop_now) rd_en_total++;
            @(posedge rclk);
            #1;
            if (pop_now && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
            if (toggle_en) begin
                tcnt++;
                if (tcnt % 3 == 0) force_empty = !force_empty;
            end else begin
                tcnt = 0;
            end
            upd_empty();
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (hold_cnt > 0) begin
                        out_ready = 1'b0;
                        hold_cnt--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops on every transfer, stall stability, done checks
    initial begin
        bit               prev_stall;
        logic [WIDTH-1:0] prev_data;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge rclk);
            if (reset) begin
                prev_stall = 0;
            end else begin
                if (empty) check("rd_en_while_empty", int'(rd_en), 0);
                if (prev_stall) begin
                    check("stall_valid_held", int'(out_valid), 1);
                    check("stall_data_held", int'(out_data), int'(prev_data));
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word_count", 1, 0 + exp_q.size());
                    end else begin
                        check("out_data", int'(out_data), int'(exp_q.pop_front()));
                    end
                    last_xfer = cyc;
                end
                if (done) begin
                    done_cnt++;
                    check("rd_count_at_done", int'(rd_count), exp_count);
                    check("words_pending_at_done", exp_q.size(), 0);
                    check("busy_at_done", int'(busy), 0);
                    if (chk_latency) check("done_latency", cyc - last_xfer, 1);
                end
            end
        end
    end

    task automatic load_seq(input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(WIDTH'(i));
        upd_empty();
    endtask

    task automatic load_rand(input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(WIDTH'($urandom));
        upd_empty();
    endtask

    // stop_after: 0 none, -1 same cycle as start, k>0 the cycle after the k-th rd_en
    task automatic run_burst(input int exp_n, input int stop_after, input int rmode,
                             input bit tog, input bit dbl_start);
        int base, d0, n_loaded;
        @(posedge rclk);
        #1;
        n_loaded = fifo_q.size();
        for (int i = 0; i < exp_n; i++) exp_q.push_back(fifo_q[i]);
        exp_count   = exp_n;
        chk_latency = (stop_after == 0) && (exp_n > 0);
        ready_mode  = rmode;
        if (rmode == 2) begin
            hold_cnt  = 20;
            out_ready = 1'b0;
        end
        toggle_en = tog;
        base      = rd_en_total;
        d0        = done_cnt;
        start     = 1'b1;
        stop      = (stop_after < 0);
        @(posedge rclk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check("busy_after_start", int'(busy), 1);
        if (dbl_start) begin
            start = 1'b1;
            @(posedge rclk);
            #1;
            start = 1'b0;
        end
        if (rmode == 2) begin
            repeat (15) @(posedge rclk);
            #1;
            check("reads_while_stalled", rd_en_total - base, 2);
            check("stalled_valid", int'(out_valid), 1);
            check("stalled_data", int'(out_data), int'(exp_q[0]));
        end
        if (stop_after > 0) begin : stop_blk
            int k;
            k = 0;
            for (int c = 0; c < 300 && k < stop_after; c++) begin
                @(negedge rclk);
                if (rd_en) k++;
            end
            check("reads_before_stop", k, stop_after);
            @(posedge rclk);
            #1 stop = 1'b1;
            @(posedge rclk);
            #1 stop = 1'b0;
        end
        for (int c = 0; c < 800 && done_cnt == d0; c++) @(negedge rclk);
        check("done_pulses", done_cnt - d0, 1);
        check("rd_en_issued", rd_en_total - base, exp_n);
        check("fifo_words_left", fifo_q.size(), n_loaded - exp_n);
        toggle_en   = 0;
        force_empty = 0;
        ready_mode  = 0;
        upd_empty();
        repeat (2) @(posedge rclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b1;
        rd_data   = '0;
        upd_empty();
        @(negedge rclk);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_count", int'(rd_count), 0);
        @(posedge rclk);
        #1 reset = 1'b0;

        // full burst, always ready
        load_seq(8);
        run_burst(8, 0, 0, 0, 0);
        // empty toggling mid-burst
        load_rand(10);
        run_burst(8, 0, 0, 1, 0);
        // consumer stalled for 20 cycles after start
        load_seq(8);
        run_burst(8, 0, 2, 0, 0);
        // stop after the third read
        load_seq(8);
        run_burst(3, 3, 0, 0, 0);
        // start and stop together: empty burst
        load_rand(4);
        run_burst(0, -1, 0, 0, 0);

        // randomized bursts: random ready, empty gaps, stops, repeated start
        for (int it = 0; it < 8; it++) begin
            int sa;
            int n;
            n  = 8 + $urandom_range(0, 4);
            sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, BL) : 0;
            load_rand(n);
            run_burst((sa == 0) ? BL : sa, sa, 1, $urandom_range(0, 1) == 1,
                      (sa == 0) && ($urandom_range(0, 1) == 1));
        end

        // reset with a read in flight
        load_seq(8);
        @(posedge rclk);
        #1 start = 1'b1;
        @(posedge rclk);
        #1 start = 1'b0;
        begin : rst_blk
            int k;
            k = 0;
            for (int c = 0; c < 100 && k < 2; c++) begin
                @(negedge rclk);
                if (rd_en) k++;
            end
            check("reads_before_reset", k, 2);
        end
        @(posedge rclk);
        #2 reset = 1'b1;
        #1;
        check("midreset_rd_en", int'(rd_en), 0);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out_data", int'(out_data), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_rd_count", int'(rd_count), 0);
        exp_q.delete();
        repeat (2) @(posedge rclk);
        #2 reset = 1'b0;
        load_seq(8);
        run_burst(8, 0, 0, 0, 0);

`ifdef FIFO_SEQ_CHECK_EN
        fifo_q.delete();
        fifo_q.push_back(4'd0);
        fifo_q.push_back(4'd1);
        fifo_q.push_back(4'd2);
        fifo_q.push_back(4'd5);
        upd_empty();
        run_burst(4, 4, 0, 0, 0);
        check("seq_err_set", int'(seq_err), 1);
        load_seq(8);
        run_burst(8, 0, 0, 0, 0);
        check("seq_err_cleared", int'(seq_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
